// File: rtl/rx_sd_ctrl_if.sv
// Receive-chain sequencer bus: detector configuration, detector and loop
// status inputs, and the registered sequencer outputs.
// master: the receive chain / host side. slave: rx_sd_ctrl.
interface rx_sd_ctrl_if #(
  parameter int WIDTH            = 16,
  parameter int MAX_WINDOW_WIDTH = 8,
  parameter int CNT_WIDTH        = 16
);
  logic [WIDTH-1:0]            cfg_threshold;
  logic [MAX_WINDOW_WIDTH-1:0] cfg_window;
  logic [CNT_WIDTH-1:0]        cfg_qual;
  logic [CNT_WIDTH-1:0]        cfg_loss;
  logic [CNT_WIDTH-1:0]        cfg_timeout;
  logic                        cfg_update;
  logic                        sd_flag;
  logic                        lock;
  logic [WIDTH-1:0]            RX_SD_THRESHOLD;
  logic [MAX_WINDOW_WIDTH-1:0] RX_SD_WINDOW;
  logic                        sd_rst;
  logic                        loop_rst;
  logic                        loop_en;
  logic                        rx_active;
  logic                        acq_fail;
  logic [2:0]                  state;

  modport master (
    output cfg_threshold, cfg_window, cfg_qual, cfg_loss, cfg_timeout,
           cfg_update, sd_flag, lock,
    input  RX_SD_THRESHOLD, RX_SD_WINDOW, sd_rst, loop_rst, loop_en,
           rx_active, acq_fail, state
  );

  modport slave (
    input  cfg_threshold, cfg_window, cfg_qual, cfg_loss, cfg_timeout,
           cfg_update, sd_flag, lock,
    output RX_SD_THRESHOLD, RX_SD_WINDOW, sd_rst, loop_rst, loop_en,
           rx_active, acq_fail, state
  );
endinterface

// File: rtl/rx_sd_ctrl.sv
// rx_sd_ctrl: signal-detect driven receive-chain sequencer.
// IDLE -> QUALIFY -> ACQUIRE -> TRACK, FLUSH on signal loss. Detector
// threshold/window updates are staged and only applied while IDLE.
// Optional: RX_SD_CTRL_ACQ_TIMEOUT_EN adds an ACQUIRE timeout that flushes
// the chain and pulses acq_fail.
module rx_sd_ctrl #(
  parameter int                          WIDTH            = 16,
  parameter int                          MAX_WINDOW_WIDTH = 8,
  parameter int                          CNT_WIDTH        = 16,
  parameter int                          FLUSH_CYCLES     = 4,
  parameter logic [WIDTH-1:0]            DEF_THRESHOLD    = 16'h7FFF,
  parameter logic [MAX_WINDOW_WIDTH-1:0] DEF_WINDOW       = 8'd16
) (
  input logic          clk,
  input logic          rst,
  rx_sd_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    QUALIFY = 3'd1,
    ACQUIRE = 3'd2,
    TRACK   = 3'd3,
    FLUSH   = 3'd4
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = 1;
  localparam logic [CNT_WIDTH-1:0] CNT_TWO    = 2;
  localparam logic [CNT_WIDTH-1:0] FLUSH_LAST = CNT_WIDTH'(FLUSH_CYCLES - 1);

  state_t                      state_q, state_d;
  logic [CNT_WIDTH-1:0]        cnt_q, cnt_d, cnt_inc;
  logic [CNT_WIDTH-1:0]        qual_lim, loss_lim;
  logic [WIDTH-1:0]            stage_thr_q, thr_q;
  logic [MAX_WINDOW_WIDTH-1:0] stage_win_q, win_q;
  logic                        pend_q;
  logic                        apply;
  logic                        acq_fail_d;
  logic                        sd_rst_q, loop_rst_q, loop_en_q, rx_active_q, acq_fail_q;
`ifdef RX_SD_CTRL_ACQ_TIMEOUT_EN
  logic [CNT_WIDTH-1:0]        tmr_q, tmr_d, tmr_inc, tmo_lim;
`endif

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  // Effective limits: qualify needs at least two samples, loss/timeout at least one.
  always_comb begin
    qual_lim = (bus.cfg_qual < CNT_TWO) ? CNT_TWO : bus.cfg_qual;
    loss_lim = (bus.cfg_loss == '0) ? CNT_ONE : bus.cfg_loss;
`ifdef RX_SD_CTRL_ACQ_TIMEOUT_EN
    tmo_lim  = (bus.cfg_timeout == '0) ? CNT_ONE : bus.cfg_timeout;
`endif
  end

  // Next-state, shared counter and apply/fail decode.
  // cnt is reused: qualify run length, consecutive-low run, flush cycle count.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cnt_inc    = sat_inc(cnt_q);
    apply      = 1'b0;
    acq_fail_d = 1'b0;
`ifdef RX_SD_CTRL_ACQ_TIMEOUT_EN
    tmr_d      = '0;
    tmr_inc    = sat_inc(tmr_q);
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (pend_q) begin
          apply = 1'b1;
        end else if (bus.sd_flag) begin
          state_d = QUALIFY;
          cnt_d   = CNT_ONE;
        end
      end
      QUALIFY: begin
        if (!bus.sd_flag) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_inc >= qual_lim) begin
          state_d = ACQUIRE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ACQUIRE: begin
        cnt_d = bus.sd_flag ? '0 : cnt_inc;
`ifdef RX_SD_CTRL_ACQ_TIMEOUT_EN
        tmr_d = tmr_inc;
`endif
        if (!bus.sd_flag && (cnt_inc >= loss_lim)) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end
`ifdef RX_SD_CTRL_ACQ_TIMEOUT_EN
        else if (tmr_inc >= tmo_lim) begin
          state_d    = FLUSH;
          cnt_d      = '0;
          acq_fail_d = 1'b1;
        end
`endif
        else if (bus.lock) begin
          state_d = TRACK;
        end
      end
      TRACK: begin
        cnt_d = bus.sd_flag ? '0 : cnt_inc;
        if (!bus.sd_flag && (cnt_inc >= loss_lim)) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end else if (!bus.lock) begin
          state_d = ACQUIRE;
        end
      end
      FLUSH: begin
        if (cnt_q >= FLUSH_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
`ifdef RX_SD_CTRL_ACQ_TIMEOUT_EN
      tmr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
`ifdef RX_SD_CTRL_ACQ_TIMEOUT_EN
      tmr_q   <= tmr_d;
`endif
    end
  end

  // Config staging and apply; an update on the apply cycle re-arms pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_thr_q <= DEF_THRESHOLD;
      stage_win_q <= DEF_WINDOW;
      pend_q      <= 1'b0;
      thr_q       <= DEF_THRESHOLD;
      win_q       <= DEF_WINDOW;
    end else begin
      if (apply) begin
        thr_q <= stage_thr_q;
        win_q <= stage_win_q;
      end
      if (bus.cfg_update) begin
        stage_thr_q <= bus.cfg_threshold;
        stage_win_q <= bus.cfg_window;
        pend_q      <= 1'b1;
      end else if (apply) begin
        pend_q <= 1'b0;
      end
    end
  end

  // Registered control outputs decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sd_rst_q    <= 1'b1;
      loop_rst_q  <= 1'b1;
      loop_en_q   <= 1'b0;
      rx_active_q <= 1'b0;
      acq_fail_q  <= 1'b0;
    end else begin
      sd_rst_q    <= (state_d == FLUSH) || apply;
      loop_rst_q  <= state_d inside {IDLE, QUALIFY, FLUSH};
      loop_en_q   <= state_d inside {ACQUIRE, TRACK};
      rx_active_q <= (state_d == TRACK);
      acq_fail_q  <= acq_fail_d;
    end
  end

  assign bus.state           = state_q;
  assign bus.RX_SD_THRESHOLD = thr_q;
  assign bus.RX_SD_WINDOW    = win_q;
  assign bus.sd_rst          = sd_rst_q;
  assign bus.loop_rst        = loop_rst_q;
  assign bus.loop_en         = loop_en_q;
  assign bus.rx_active       = rx_active_q;
  assign bus.acq_fail        = acq_fail_q;

endmodule

// File: tb/tb_rx_sd_ctrl.sv
// Self-checking bench for rx_sd_ctrl: directed sequences plus randomized
// stimulus, all compared against a behavioural model of the sequencer.
module tb_rx_sd_ctrl;

  localparam int WIDTH        = 16;
  localparam int MWW          = 8;
  localparam int CW           = 16;
  localparam int FLUSH_CYCLES = 4;
`ifdef RX_SD_CTRL_ACQ_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rx_sd_ctrl_if #(.WIDTH(WIDTH), .MAX_WINDOW_WIDTH(MWW), .CNT_WIDTH(CW)) bus ();

  rx_sd_ctrl #(
    .WIDTH(WIDTH), .MAX_WINDOW_WIDTH(MWW), .CNT_WIDTH(CW),
    .FLUSH_CYCLES(FLUSH_CYCLES), .DEF_THRESHOLD(16'h7FFF), .DEF_WINDOW(8'd16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: spec state codes, run lengths, flush countdown.
  int               m_st, m_hi, m_lo, m_tmr, m_fl;
  logic [WIDTH-1:0] m_sthr, m_thr;
  logic [MWW-1:0]   m_swin, m_win;
  bit               m_pend;
  bit               e_sd_rst, e_loop_rst, e_loop_en, e_rx_active, e_acq_fail;

  task automatic model_reset();
    m_st = 0; m_hi = 0; m_lo = 0; m_tmr = 0; m_fl = 0;
    m_sthr = 16'h7FFF; m_thr = 16'h7FFF;
    m_swin = 8'd16;    m_win = 8'd16;
    m_pend = 0;
    e_sd_rst = 1; e_loop_rst = 1; e_loop_en = 0; e_rx_active = 0; e_acq_fail = 0;
  endtask

  task automatic model_step();
    int q, l, t, nst;
    bit apply, fail, sd, lk;
    sd = bus.sd_flag; lk = bus.lock;
    q = (int'(bus.cfg_qual) < 2) ? 2 : int'(bus.cfg_qual);
    l = (int'(bus.cfg_loss) < 1) ? 1 : int'(bus.cfg_loss);
    t = (int'(bus.cfg_timeout) < 1) ? 1 : int'(bus.cfg_timeout);
    nst = m_st; apply = 0; fail = 0;
    case (m_st)
      0: begin
        if (m_pend) begin
          apply = 1; m_thr = m_sthr; m_win = m_swin;
        end else if (sd) begin
          nst = 1; m_hi = 1;
        end
      end
      1: begin
        if (!sd) nst = 0;
        else begin
          m_hi++;
          if (m_hi >= q) begin nst = 2; m_lo = 0; m_tmr = 0; end
        end
      end
      2: begin
        m_lo = sd ? 0 : m_lo + 1;
        m_tmr++;
        if (m_lo >= l) begin nst = 4; m_fl = FLUSH_CYCLES; end
        else if (TMO_EN && m_tmr >= t) begin nst = 4; m_fl = FLUSH_CYCLES; fail = 1; end
        else if (lk) nst = 3;
      end
      3: begin
        m_lo = sd ? 0 : m_lo + 1;
        if (m_lo >= l) begin nst = 4; m_fl = FLUSH_CYCLES; end
        else if (!lk) begin nst = 2; m_tmr = 0; end
      end
      default: begin
        m_fl--;
        if (m_fl == 0) nst = 0;
      end
    endcase
    if (bus.cfg_update) begin
      m_sthr = bus.cfg_threshold; m_swin = bus.cfg_window; m_pend = 1;
    end else if (apply) begin
      m_pend = 0;
    end
    m_st        = nst;
    e_sd_rst    = (nst == 4) || apply;
    e_loop_rst  = (nst == 0) || (nst == 1) || (nst == 4);
    e_loop_en   = (nst == 2) || (nst == 3);
    e_rx_active = (nst == 3);
    e_acq_fail  = fail;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".state"},     bus.state,           m_st);
    check({tag, ".thr"},       bus.RX_SD_THRESHOLD, m_thr);
    check({tag, ".win"},       bus.RX_SD_WINDOW,    m_win);
    check({tag, ".sd_rst"},    bus.sd_rst,          e_sd_rst);
    check({tag, ".loop_rst"},  bus.loop_rst,        e_loop_rst);
    check({tag, ".loop_en"},   bus.loop_en,         e_loop_en);
    check({tag, ".rx_active"}, bus.rx_active,       e_rx_active);
    check({tag, ".acq_fail"},  bus.acq_fail,        e_acq_fail);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".state"},     bus.state,           0);
    check({tag, ".thr"},       bus.RX_SD_THRESHOLD, 16'h7FFF);
    check({tag, ".win"},       bus.RX_SD_WINDOW,    16);
    check({tag, ".sd_rst"},    bus.sd_rst,          1);
    check({tag, ".loop_rst"},  bus.loop_rst,        1);
    check({tag, ".loop_en"},   bus.loop_en,         0);
    check({tag, ".rx_active"}, bus.rx_active,       0);
    check({tag, ".acq_fail"},  bus.acq_fail,        0);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all("cyc");
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic cfg_pulse(input logic [WIDTH-1:0] thr, input logic [MWW-1:0] win);
    bus.cfg_threshold = thr;
    bus.cfg_window    = win;
    bus.cfg_update    = 1'b1;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int acq_cycles, fail_seen, p_hi;
    bit done;

    rst = 1'b1;
    bus.cfg_threshold = '0; bus.cfg_window = '0;
    bus.cfg_qual = 16'd4; bus.cfg_loss = 16'd8; bus.cfg_timeout = 16'd100;
    bus.cfg_update = 1'b0; bus.sd_flag = 1'b0; bus.lock = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;

    // Config apply while IDLE
    cfg_pulse(16'd1000, 8'd32);
    cycle();
    bus.cfg_update = 1'b0;
    cycle();
    check("apply1.thr", bus.RX_SD_THRESHOLD, 1000);
    check("apply1.win", bus.RX_SD_WINDOW, 32);
    check("apply1.sd_rst", bus.sd_rst, 1);
    cycle();
    check("apply1.sd_rst_end", bus.sd_rst, 0);

    // Qualification: 3 highs fall back, 4 highs enter ACQUIRE
    bus.sd_flag = 1'b1; run(3);
    bus.sd_flag = 1'b0; run(1);
    check("qual3.state", bus.state, 0);
    check("qual3.loop_rst", bus.loop_rst, 1);
    bus.sd_flag = 1'b1; run(3);
    check("qual.mid", bus.state, 1);
    run(1);
    check("qual4.state", bus.state, 2);
    check("qual4.loop_en", bus.loop_en, 1);
    check("qual4.loop_rst", bus.loop_rst, 0);

    // Lock -> TRACK; loss run interrupted, then a full loss run
    bus.lock = 1'b1; run(1);
    check("track.state", bus.state, 3);
    check("track.rx_active", bus.rx_active, 1);
    bus.sd_flag = 1'b0; run(7);
    bus.sd_flag = 1'b1; run(1);
    bus.sd_flag = 1'b0; run(7);
    check("loss7.state", bus.state, 3);
    run(1);
    check("loss8.state", bus.state, 4);
    check("flush.sd_rst", bus.sd_rst, 1);
    check("flush.loop_rst", bus.loop_rst, 1);
    run(3);
    check("flush4.state", bus.state, 4);
    run(1);
    check("flush_end.state", bus.state, 0);

    // Update while TRACK is deferred until the return to IDLE
    bus.sd_flag = 1'b1; run(5);
    check("track2.state", bus.state, 3);
    cfg_pulse(16'd2000, 8'd64);
    run(1);
    bus.cfg_update = 1'b0;
    check("defer.track_thr", bus.RX_SD_THRESHOLD, 1000);
    bus.sd_flag = 1'b0; run(8);
    check("defer.flush_thr", bus.RX_SD_THRESHOLD, 1000);
    run(4);
    check("defer.idle_thr", bus.RX_SD_THRESHOLD, 1000);
    run(1);
    check("defer.apply_thr", bus.RX_SD_THRESHOLD, 2000);
    check("defer.apply_win", bus.RX_SD_WINDOW, 64);
    check("defer.sd_rst", bus.sd_rst, 1);
    run(1);
    check("defer.sd_rst_end", bus.sd_rst, 0);

    // Update coinciding with apply -> two back-to-back applies
    cfg_pulse(16'd3000, 8'd3);
    run(1);
    cfg_pulse(16'd4000, 8'd4);
    run(1);
    bus.cfg_update = 1'b0;
    check("dbl1.thr", bus.RX_SD_THRESHOLD, 3000);
    check("dbl1.sd_rst", bus.sd_rst, 1);
    run(1);
    check("dbl2.thr", bus.RX_SD_THRESHOLD, 4000);
    check("dbl2.sd_rst", bus.sd_rst, 1);
    run(1);
    check("dbl.sd_rst_end", bus.sd_rst, 0);

    // ACQUIRE with no lock: timeout (feature) or indefinite wait
    bus.lock = 1'b0; bus.cfg_timeout = 16'd100; bus.sd_flag = 1'b1;
    run(4);
    check("tmo.enter", bus.state, 2);
    acq_cycles = 1; fail_seen = 0; done = 0;
    for (int i = 0; i < 149 && !done; i++) begin
      cycle();
      if (bus.acq_fail) fail_seen++;
      if (bus.state == 3'd2) acq_cycles++;
      else done = 1;
    end
    repeat (3) begin
      cycle();
      if (bus.acq_fail) fail_seen++;
    end
    check("tmo.acq_len", acq_cycles, TMO_EN ? 100 : 150);
    check("tmo.fail_pulses", fail_seen, TMO_EN ? 1 : 0);
    bus.sd_flag = 1'b0; run(12);
    check("tmo.idle", bus.state, 0);

    // Randomized phase
    for (int blk = 0; blk < 8; blk++) begin
      bus.cfg_qual    = 16'($urandom_range(0, 5));
      bus.cfg_loss    = 16'($urandom_range(0, 6));
      bus.cfg_timeout = 16'($urandom_range(0, 30));
      p_hi = (blk % 3 == 0) ? 95 : ((blk % 3 == 1) ? 80 : 60);
      for (int i = 0; i < 500; i++) begin
        bus.sd_flag    = ($urandom_range(0, 99) < p_hi);
        bus.lock       = ($urandom_range(0, 99) < 30);
        bus.cfg_update = ($urandom_range(0, 15) == 0);
        bus.cfg_threshold = 16'($urandom());
        bus.cfg_window    = 8'($urandom());
        cycle();
      end
    end
    bus.cfg_update = 1'b0;

    // Asynchronous reset while in TRACK
    bus.sd_flag = 1'b0; bus.lock = 1'b0;
    bus.cfg_qual = 16'd4; bus.cfg_loss = 16'd8;
    #2 rst = 1'b1;
    #1 model_reset();
    @(negedge clk);
    rst = 1'b0;
    cfg_pulse(16'd555, 8'd5);
    cycle();
    bus.cfg_update = 1'b0;
    bus.sd_flag = 1'b1;
    run(1);
    check("pre_trk.thr", bus.RX_SD_THRESHOLD, 555);
    run(4);
    bus.lock = 1'b1;
    run(1);
    check("pre_rst.state", bus.state, 3);
    cfg_pulse(16'd777, 8'd7);
    run(1);
    bus.cfg_update = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset_vals("async_rst");
    model_reset();
    @(negedge clk);
    check_all("rst_hold");
    rst = 1'b0;
    bus.sd_flag = 1'b0;
    run(3);
    check("rst.stage_lost", bus.RX_SD_THRESHOLD, 16'h7FFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
